// File: rtl/song_recorder_if.sv
// song_recorder_if: recorder key/octave inputs, read port and status bundle.
// master drives keys and read address; slave is the recorder.
interface song_recorder_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          rec_enable;
  logic [6:0]    key_in;
  logic [1:0]    octave_keys;
  logic [AW-1:0] rd_addr;
  logic [13:0]   rd_data;
  logic [AW:0]   rec_count;
  logic          recording;
  logic          full;
  logic [3:0]    note_out;

  modport master (
    output rec_enable,
    output key_in,
    output octave_keys,
    output rd_addr,
    input  rd_data,
    input  rec_count,
    input  recording,
    input  full,
    input  note_out
  );

  modport slave (
    input  rec_enable,
    input  key_in,
    input  octave_keys,
    input  rd_addr,
    output rd_data,
    output rec_count,
    output recording,
    output full,
    output note_out
  );
endinterface

// File: rtl/song_recorder.sv
// song_recorder: captures played notes, octaves and durations as song entries.
// Writer side of the song memory format that the auto-play path reads back.
module song_recorder #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 1_000_000
) (
  input logic            clk,
  input logic            reset,
  song_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0] TICK_MAX   = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_FIRST = (TICK_DIV > 1) ? TW'(1) : TW'(0);
  localparam logic [7:0]    DUR_FIRST  = (TICK_DIV > 1) ? 8'd0 : 8'd1;
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [6:0]    key_s1, key_s2;
  logic [1:0]    oct_s1, oct_s2;
  logic [3:0]    note;
  logic [1:0]    oct;
  logic [5:0]    sym;

  logic [1:0]    state;
  logic          rec_en_q;
  logic [5:0]    cur_sym;
  logic [7:0]    dur;
  logic [TW-1:0] tick;
  logic [AW:0]   rec_count;
  logic          full;
  logic [13:0]   rd_q;

  logic          rise, fall, change, wrap;
  logic          wr_en;
  logic [7:0]    wr_dur;
  logic [AW:0]   cnt_nxt;

  logic [13:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      oct_s1 <= '0;
      oct_s2 <= '0;
    end else begin
      key_s1 <= bus.key_in;
      key_s2 <= key_s1;
      oct_s1 <= bus.octave_keys;
      oct_s2 <= oct_s1;
    end
  end

  // Lowest pressed key wins when several are held.
  always_comb begin
    note = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (key_s2[i]) note = 4'(i + 1);
    end
  end

  always_comb begin
    unique case (1'b1)
      oct_s2 == 2'b01: oct = 2'd2;
      oct_s2 == 2'b10: oct = 2'd0;
      default:         oct = 2'd1;
    endcase
  end

  assign sym     = {note, oct};
  assign rise    = bus.rec_enable & ~rec_en_q;
  assign fall    = ~bus.rec_enable & rec_en_q;
  assign change  = sym != cur_sym;
  assign wrap    = tick == TICK_MAX;
  assign cnt_nxt = rec_count + 1'b1;

  // A note reaching 255 ticks is split so long holds keep their length.
  always_comb begin
    wr_en  = 1'b0;
    wr_dur = dur;
    if (reset && state == S_CAPTURE) begin
      if (fall) begin
        wr_en = (dur != 8'd0) && (cur_sym[5:2] != 4'd0);
      end else if (change) begin
        wr_en = dur != 8'd0;
      end else if (wrap && dur == 8'd254) begin
        wr_en  = 1'b1;
        wr_dur = 8'd255;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      rec_en_q  <= 1'b0;
      cur_sym   <= '0;
      dur       <= '0;
      tick      <= '0;
      rec_count <= '0;
      full      <= 1'b0;
    end else begin
      rec_en_q <= bus.rec_enable;
      if (wr_en) rec_count <= cnt_nxt;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (rise) begin
            rec_count <= '0;
            full      <= 1'b0;
            state     <= S_ARM;
          end
        end
        S_ARM: begin
          if (fall) begin
            state <= S_DONE;
          end else if (note != 4'd0) begin
            cur_sym <= sym;
            dur     <= DUR_FIRST;
            tick    <= TICK_FIRST;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // The detecting cycle already belongs to the new symbol.
          if (wr_en && cnt_nxt == CNT_FULL) begin
            full  <= 1'b1;
            state <= S_DONE;
          end else if (fall) begin
            state <= S_DONE;
          end else if (change) begin
            cur_sym <= sym;
            dur     <= DUR_FIRST;
            tick    <= TICK_FIRST;
          end else if (wrap) begin
            tick <= '0;
            dur  <= (dur == 8'd254) ? 8'd0 : dur + 8'd1;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[rec_count[AW-1:0]] <= {cur_sym, wr_dur};
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_q <= '0;
    else        rd_q <= mem[bus.rd_addr];
  end

  assign bus.rd_data   = rd_q;
  assign bus.rec_count = rec_count;
  assign bus.recording = (state == S_ARM) || (state == S_CAPTURE);
  assign bus.full      = full;
  assign bus.note_out  = note;
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed scenarios for the song recorder.
// Two instances: DEPTH 64 for recording behaviour, DEPTH 4 for the full case.
module tb_song_recorder;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  song_recorder_if #(.DEPTH(64)) bm ();
  song_recorder_if #(.DEPTH(4))  bf ();

  song_recorder #(.DEPTH(64), .TICK_DIV(4)) u_main (
    .clk(clk), .reset(reset), .bus(bm.slave)
  );
  song_recorder #(.DEPTH(4), .TICK_DIV(4)) u_full (
    .clk(clk), .reset(reset), .bus(bf.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] ent(input int n, input int o, input int d);
    return {n[3:0], o[1:0], d[7:0]};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bm.key_in = (i % 2 == 0) ? 7'b0000101 : 7'b1000000;
      bf.key_in = bm.key_in;
      step(1);
    end
    n_cmp++;
    if (bm.rec_count !== 7'd0) begin
      n_bad++; $display("FAIL reset_count got %0d want 0", bm.rec_count);
    end
    n_cmp++;
    if (bm.recording !== 1'b0) begin
      n_bad++; $display("FAIL reset_recording got %b want 0", bm.recording);
    end
    n_cmp++;
    if (bm.full !== 1'b0) begin
      n_bad++; $display("FAIL reset_full got %b want 0", bm.full);
    end
    n_cmp++;
    if (bm.rd_data !== 14'd0) begin
      n_bad++; $display("FAIL reset_rd_data got %h want 0", bm.rd_data);
    end
    n_cmp++;
    if (bm.note_out !== 4'd0) begin
      n_bad++; $display("FAIL reset_note got %0d want 0", bm.note_out);
    end
    bm.key_in = '0;
    bf.key_in = '0;
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    logic [13:0] exp_e [3];
    exp_e = '{ent(1, 1, 10), ent(3, 1, 5), ent(0, 1, 3)};
    bm.rec_enable = 1'b1;
    step(1);
    n_cmp++;
    if (bm.recording !== 1'b1) begin
      n_bad++; $display("FAIL basic_rec_rise got %b want 1", bm.recording);
    end
    step(1);
    bm.key_in = 7'b0000001; step(40);
    bm.key_in = 7'b0000100; step(20);
    n_cmp++;
    if (bm.note_out !== 4'd3) begin
      n_bad++; $display("FAIL basic_note_out got %0d want 3", bm.note_out);
    end
    bm.key_in = 7'b0000000; step(12);
    bm.key_in = 7'b0000001; step(3);
    bm.rec_enable = 1'b0;
    step(1);
    n_cmp++;
    if (bm.rec_count !== 7'd3) begin
      n_bad++; $display("FAIL basic_count got %0d want 3", bm.rec_count);
    end
    n_cmp++;
    if (bm.recording !== 1'b0 || bm.full !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_status got rec=%b full=%b want 0 0",
               bm.recording, bm.full);
    end
    bm.key_in = '0;
    for (int i = 0; i < 3; i++) begin
      bm.rd_addr = 6'(i);
      step(1);
      n_cmp++;
      if (bm.rd_data !== exp_e[i]) begin
        n_bad++;
        $display("FAIL basic_entry%0d got %h want %h", i, bm.rd_data, exp_e[i]);
      end
    end
  endtask

  task automatic test_trailing_rest();
    bm.rec_enable = 1'b1;
    step(1);
    n_cmp++;
    if (bm.rec_count !== 7'd0) begin
      n_bad++; $display("FAIL rest_clear got %0d want 0", bm.rec_count);
    end
    step(1);
    bm.key_in = 7'b0000001; step(40);
    bm.key_in = 7'b0000100; step(20);
    bm.key_in = 7'b0000000; step(12);
    bm.rec_enable = 1'b0;
    step(2);
    n_cmp++;
    if (bm.rec_count !== 7'd2) begin
      n_bad++; $display("FAIL rest_count got %0d want 2", bm.rec_count);
    end
    bm.rd_addr = 6'd2;
    step(1);
    n_cmp++;
    if (bm.rd_data !== ent(0, 1, 3)) begin
      n_bad++; $display("FAIL rest_stale got %h want %h", bm.rd_data, ent(0, 1, 3));
    end
  endtask

  task automatic test_long_note();
    logic [13:0] exp_e [2];
    exp_e = '{ent(5, 2, 255), ent(5, 2, 20)};
    bm.rec_enable = 1'b1;
    step(2);
    bm.key_in = 7'b0010000;
    bm.octave_keys = 2'b01;
    step(1100);
    bm.key_in = '0;
    bm.octave_keys = 2'b00;
    step(2);
    bm.rec_enable = 1'b0;
    step(2);
    n_cmp++;
    if (bm.rec_count !== 7'd2) begin
      n_bad++; $display("FAIL long_count got %0d want 2", bm.rec_count);
    end
    for (int i = 0; i < 2; i++) begin
      bm.rd_addr = 6'(i);
      step(1);
      n_cmp++;
      if (bm.rd_data !== exp_e[i]) begin
        n_bad++;
        $display("FAIL long_entry%0d got %h want %h", i, bm.rd_data, exp_e[i]);
      end
    end
  endtask

  task automatic test_glitch();
    bm.rec_enable = 1'b1;
    step(2);
    bm.key_in = 7'b0000001; step(40);
    bm.key_in = 7'b0000010; step(2);
    bm.key_in = 7'b0000001; step(40);
    bm.key_in = 7'b0000000; step(2);
    bm.rec_enable = 1'b0;
    step(2);
    n_cmp++;
    if (bm.rec_count !== 7'd2) begin
      n_bad++; $display("FAIL glitch_count got %0d want 2", bm.rec_count);
    end
    for (int i = 0; i < 2; i++) begin
      bm.rd_addr = 6'(i);
      step(1);
      n_cmp++;
      if (bm.rd_data !== ent(1, 1, 10)) begin
        n_bad++;
        $display("FAIL glitch_entry%0d got %h want %h", i, bm.rd_data, ent(1, 1, 10));
      end
    end
  endtask

  task automatic test_full();
    bf.rec_enable = 1'b1;
    step(2);
    for (int s = 0; s < 7; s++) begin
      bf.key_in = (s % 2 == 0) ? 7'b0000001 : 7'b0000010;
      step(8);
      if (s == 2) begin
        n_cmp++;
        if (bf.rec_count !== 3'd2 || bf.recording !== 1'b1) begin
          n_bad++;
          $display("FAIL full_mid got cnt=%0d rec=%b want 2 1",
                   bf.rec_count, bf.recording);
        end
      end
    end
    bf.key_in = '0;
    step(4);
    n_cmp++;
    if (bf.rec_count !== 3'd4) begin
      n_bad++; $display("FAIL full_count got %0d want 4", bf.rec_count);
    end
    n_cmp++;
    if (bf.full !== 1'b1 || bf.recording !== 1'b0) begin
      n_bad++;
      $display("FAIL full_flags got full=%b rec=%b want 1 0", bf.full, bf.recording);
    end
    for (int i = 0; i < 4; i++) begin
      bf.rd_addr = 2'(i);
      step(1);
      n_cmp++;
      if (bf.rd_data !== ent((i % 2) + 1, 1, 2)) begin
        n_bad++;
        $display("FAIL full_entry%0d got %h want %h", i, bf.rd_data,
                 ent((i % 2) + 1, 1, 2));
      end
    end
    bf.rec_enable = 1'b0;
    step(1);
    bf.rec_enable = 1'b1;
    step(1);
    n_cmp++;
    if (bf.full !== 1'b0 || bf.rec_count !== 3'd0) begin
      n_bad++;
      $display("FAIL full_rearm got full=%b cnt=%0d want 0 0", bf.full, bf.rec_count);
    end
    bf.rec_enable = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid();
    bm.rec_enable = 1'b1;
    step(2);
    bm.key_in = 7'b0000001; step(40);
    bm.key_in = 7'b0000100; step(10);
    n_cmp++;
    if (bm.rec_count !== 7'd1 || bm.recording !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre got cnt=%0d rec=%b want 1 1", bm.rec_count, bm.recording);
    end
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    bm.rec_enable = 1'b0;
    bm.key_in = '0;
    bm.rd_addr = 6'd0;
    n_cmp++;
    if (bm.rec_count !== 7'd0 || bm.recording !== 1'b0 || bm.rd_data !== 14'd0) begin
      n_bad++;
      $display("FAIL mid_reset got cnt=%0d rec=%b rd=%h want 0 0 0",
               bm.rec_count, bm.recording, bm.rd_data);
    end
    step(1);
    n_cmp++;
    if (bm.rd_data !== ent(1, 1, 10)) begin
      n_bad++; $display("FAIL mid_read0 got %h want %h", bm.rd_data, ent(1, 1, 10));
    end
    bm.rd_addr = 6'd1;
    step(1);
    n_cmp++;
    if (bm.rd_data !== ent(1, 1, 10)) begin
      n_bad++; $display("FAIL mid_read1 got %h want %h", bm.rd_data, ent(1, 1, 10));
    end
    n_cmp++;
    if (bm.rec_count !== 7'd0) begin
      n_bad++; $display("FAIL mid_count got %0d want 0", bm.rec_count);
    end
  endtask

  initial begin
    reset = 1'b0;
    bm.rec_enable = 1'b0;
    bm.key_in = '0;
    bm.octave_keys = '0;
    bm.rd_addr = '0;
    bf.rec_enable = 1'b0;
    bf.key_in = '0;
    bf.octave_keys = '0;
    bf.rd_addr = '0;
    test_reset();
    test_basic();
    test_trailing_rest();
    test_long_note();
    test_glitch();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
